alu_result_checker: RTL and testbench

- Response-side companion to the 4-bit ALU: consumes completed ALU transactions (select, operands, F, COUT) and checks each against an internal reference model.
- Keeps pass/fail counts and captures the first mismatch, so ALU bring-up and regression can self-check in simulation or on FPGA.
- Sits between the ALU output and a status register bank or monitor.
- Input uses a valid/ready handshake; a run is armed by `start` and ends after a programmed number of checks.

---
 rtl/alu_chk_pkg.sv | 22 ++
 rtl/alu_ref_model.sv | 27 ++
 rtl/alu_result_checker.sv | 170 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: shared opcodes, FSM encoding and expected-result record for the ALU result checker
package alu_chk_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    typedef struct packed {
        logic [DATA_W_DEF-1:0] exp_f;
        logic                  exp_cout;
    } exp_t;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational reference for the 4-bit ALU, (sel, a, b) -> (exp_f, exp_cout)
module alu_ref_model
    import alu_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] exp_f,
    output logic              exp_cout
);
    logic [DATA_W-1:0] addend;
    logic              cin;
    logic [DATA_W:0]   sum;
    // all arithmetic ops share one adder: pick the addend and carry-in, take the carry from the top bit
    always_comb begin
        addend   = sel == OP_ADD ? b : sel == OP_SUB ? ~b : sel == OP_INC ? '0 : '1;
        cin      = (sel == OP_SUB) || (sel == OP_INC);
        sum      = {1'b0, a} + {1'b0, addend} + (DATA_W+1)'(cin);
        exp_f    = sel == OP_AND ? a & b :
                   sel == OP_OR  ? a | b :
                   sel == OP_XOR ? a ^ b :
                   sel == OP_NOT ? ~a    : sum[DATA_W-1:0];
        exp_cout = sel[2] ? 1'b0 : sum[DATA_W];
    end
endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: checks ALU transactions against alu_ref_model, counts pass/fail, captures first failure.
// Optional ALU_CHK_COVER_EN adds op_seen[7:0] opcode coverage and makes all_pass require every opcode.
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_checks,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_f,
    input  logic              in_cout,
    output logic              busy,
    output logic              done,
    output logic              all_pass,
`ifdef ALU_CHK_COVER_EN
    output logic [7:0]        op_seen,
`endif
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              ff_valid,
    output logic [CNT_W-1:0]  ff_idx,
    output logic [2:0]        ff_sel,
    output logic [DATA_W-1:0] ff_a,
    output logic [DATA_W-1:0] ff_b,
    output logic [DATA_W-1:0] ff_f,
    output logic              ff_cout,
    output logic [DATA_W-1:0] ff_exp_f,
    output logic              ff_exp_cout
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d, acc_q, acc_d, pass_q, pass_d, fail_q, fail_d;
    logic              s1_valid_q, s1_valid_d, s1_cout_q, s1_cout_d;
    logic [CNT_W-1:0]  s1_idx_q, s1_idx_d;
    logic [2:0]        s1_sel_q, s1_sel_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_f_q, s1_f_d;
    exp_t              s1_exp_q, s1_exp_d, ref_exp;
    logic              ff_valid_q, ff_valid_d, ff_cout_q, ff_cout_d;
    logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
    logic [2:0]        ff_sel_q, ff_sel_d;
    logic [DATA_W-1:0] ff_a_q, ff_a_d, ff_b_q, ff_b_d, ff_f_q, ff_f_d;
    exp_t              ff_exp_q, ff_exp_d;
    logic              accept, cmp, mism, ld_ff;

    alu_ref_model #(.DATA_W(DATA_W)) u_ref (
        .sel      (in_sel),
        .a        (in_a),
        .b        (in_b),
        .exp_f    (ref_exp.exp_f),
        .exp_cout (ref_exp.exp_cout)
    );

    assign in_ready = (state_q == ST_RUN) && (acc_q < num_q) && !start;
    assign accept   = in_valid && in_ready;
    assign cmp      = s1_valid_q && !start;
    assign mism     = (s1_f_q != s1_exp_q.exp_f) || (s1_cout_q != s1_exp_q.exp_cout);
    assign ld_ff    = cmp && mism && !ff_valid_q;
    assign busy     = state_q == ST_RUN;
    assign done     = state_q == ST_DONE;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign ff_valid = ff_valid_q;
    assign ff_idx   = ff_idx_q;
    assign ff_sel   = ff_sel_q;
    assign ff_a     = ff_a_q;
    assign ff_b     = ff_b_q;
    assign ff_f     = ff_f_q;
    assign ff_cout  = ff_cout_q;
    assign ff_exp_f    = ff_exp_q.exp_f;
    assign ff_exp_cout = ff_exp_q.exp_cout;

    // next state: start (re)arms the run, RUN drains to DONE once every check has left stage 2
    always_comb begin
        state_d    = start ? (num_checks != '0 ? ST_RUN : ST_DONE) :
                     (state_q == ST_RUN && acc_q == num_q && !s1_valid_q) ? ST_DONE : state_q;
        num_d      = start ? num_checks : num_q;
        acc_d      = start ? '0 : acc_q + CNT_W'(accept);
        s1_valid_d = accept;
        s1_idx_d   = accept ? acc_q   : s1_idx_q;
        s1_sel_d   = accept ? in_sel  : s1_sel_q;
        s1_a_d     = accept ? in_a    : s1_a_q;
        s1_b_d     = accept ? in_b    : s1_b_q;
        s1_f_d     = accept ? in_f    : s1_f_q;
        s1_cout_d  = accept ? in_cout : s1_cout_q;
        s1_exp_d   = accept ? ref_exp : s1_exp_q;
        pass_d     = start ? '0 : (cmp && !mism && pass_q != '1) ? pass_q + CNT_W'(1) : pass_q;
        fail_d     = start ? '0 : (cmp && mism && fail_q != '1) ? fail_q + CNT_W'(1) : fail_q;
        ff_valid_d = start ? 1'b0 : ff_valid_q || (cmp && mism);
        ff_idx_d   = start ? '0   : ld_ff ? s1_idx_q  : ff_idx_q;
        ff_sel_d   = start ? '0   : ld_ff ? s1_sel_q  : ff_sel_q;
        ff_a_d     = start ? '0   : ld_ff ? s1_a_q    : ff_a_q;
        ff_b_d     = start ? '0   : ld_ff ? s1_b_q    : ff_b_q;
        ff_f_d     = start ? '0   : ld_ff ? s1_f_q    : ff_f_q;
        ff_cout_d  = start ? 1'b0 : ld_ff ? s1_cout_q : ff_cout_q;
        ff_exp_d   = start ? '0   : ld_ff ? s1_exp_q  : ff_exp_q;
    end

    // state, pipeline and status registers; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_sel_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_f_q     <= '0;
            s1_cout_q  <= 1'b0;
            s1_exp_q   <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_sel_q   <= '0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_f_q     <= '0;
            ff_cout_q  <= 1'b0;
            ff_exp_q   <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_sel_q   <= s1_sel_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_f_q     <= s1_f_d;
            s1_cout_q  <= s1_cout_d;
            s1_exp_q   <= s1_exp_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_sel_q   <= ff_sel_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_f_q     <= ff_f_d;
            ff_cout_q  <= ff_cout_d;
            ff_exp_q   <= ff_exp_d;
        end
    end

`ifdef ALU_CHK_COVER_EN
    logic [7:0] op_seen_q, op_seen_d;
    assign op_seen  = op_seen_q;
    assign all_pass = done && fail_q == '0 && op_seen_q == 8'hFF;
    // mark each opcode as it is compared; cleared on start
    always_comb begin
        op_seen_d = start ? '0 : cmp ? op_seen_q | (8'd1 << s1_sel_q) : op_seen_q;
    end
    // opcode coverage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_seen_q <= '0;
        else        op_seen_q <= op_seen_d;
    end
`else
    assign all_pass = done && fail_q == '0;
`endif
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed self-checking bench for alu_result_checker (honours ALU_CHK_COVER_EN)
module tb_alu_result_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_checks = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = '0;
    logic [3:0]  in_a = '0, in_b = '0, in_f = '0;
    logic        in_cout = 1'b0;
    logic        busy, done, all_pass, ff_valid, ff_cout, ff_exp_cout;
    logic [15:0] pass_cnt, fail_cnt, ff_idx;
    logic [2:0]  ff_sel;
    logic [3:0]  ff_a, ff_b, ff_f, ff_exp_f;
`ifdef ALU_CHK_COVER_EN
    logic [7:0]  op_seen;
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif
    int errors = 0;
    int checks = 0;
    logic [3:0] exp_f_tab [8] = '{4'h8, 4'h2, 4'h6, 4'h4, 4'h1, 4'h7, 4'h6, 4'hA};
    logic       exp_c_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    alu_result_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_checks(num_checks),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_a(in_a),
        .in_b(in_b), .in_f(in_f), .in_cout(in_cout), .busy(busy), .done(done),
        .all_pass(all_pass),
`ifdef ALU_CHK_COVER_EN
        .op_seen(op_seen),
`endif
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ff_valid(ff_valid),
        .ff_idx(ff_idx), .ff_sel(ff_sel), .ff_a(ff_a), .ff_b(ff_b), .ff_f(ff_f),
        .ff_cout(ff_cout), .ff_exp_f(ff_exp_f), .ff_exp_cout(ff_exp_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start = 1'b1;
        num_checks = n;
        #1 chk("ready_low_at_start", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic xfer(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] f, input logic c);
        int n;
        n = 0;
        in_valid = 1'b1; in_sel = s; in_a = a; in_b = b; in_f = f; in_cout = c;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("xfer_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_all_pass", all_pass, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ff_valid", ff_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // all eight opcodes, correct responses, A=5 B=3
        pulse_start(16'd8);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 8; i++) xfer(3'(i), 4'h5, 4'h3, exp_f_tab[i], exp_c_tab[i]);
        in_valid = 1'b0;
        chk("t1_pass_mid", pass_cnt, 7);
        chk("t1_done_early", done, 0);
        @(negedge clk);
        chk("t1_pass", pass_cnt, 8);
        chk("t1_done_1cyc", done, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_all_pass", all_pass, 1);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_busy_end", busy, 0);
`ifdef ALU_CHK_COVER_EN
        chk("t1_op_seen", op_seen, 8'hFF);
`endif

        // 3rd reports F=5, 6th reports COUT=1
        pulse_start(16'd8);
        chk("t2_pass_clr", pass_cnt, 0);
        chk("t2_done_clr", done, 0);
        for (int i = 0; i < 8; i++)
            xfer(3'(i), 4'h5, 4'h3, i == 2 ? 4'h5 : exp_f_tab[i], i == 5 ? 1'b1 : exp_c_tab[i]);
        drain();
        chk("t2_done", done, 1);
        chk("t2_pass", pass_cnt, 6);
        chk("t2_fail", fail_cnt, 2);
        chk("t2_all_pass", all_pass, 0);
        chk("t2_ff_valid", ff_valid, 1);
        chk("t2_ff_idx", ff_idx, 2);
        chk("t2_ff_sel", ff_sel, 3'b010);
        chk("t2_ff_a", ff_a, 4'h5);
        chk("t2_ff_b", ff_b, 4'h3);
        chk("t2_ff_f", ff_f, 4'h5);
        chk("t2_ff_cout", ff_cout, 0);
        chk("t2_ff_exp_f", ff_exp_f, 4'h6);
        chk("t2_ff_exp_cout", ff_exp_cout, 0);

        // 3 checks, 5 offered
        pulse_start(16'd3);
        chk("t3_ff_cleared", ff_valid, 0);
        for (int i = 0; i < 3; i++) xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        #1 chk("t3_ready_after3", in_ready, 0);
        repeat (2) @(negedge clk);
        chk("t3_ready_held", in_ready, 0);
        chk("t3_pass", pass_cnt, 3);
        chk("t3_done", done, 1);
        chk("t3_all_pass", all_pass, !COV);
        in_valid = 1'b0;

        // random in_valid, then reset mid-run
        pulse_start(16'd8);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel = 3'b000; in_a = 4'h1; in_b = 4'h2; in_f = 4'h3; in_cout = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ready", in_ready, 0);
        chk("t4_rst_pass", pass_cnt, 0);
        chk("t4_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        pulse_start(16'd2);
        for (int i = 0; i < 2; i++) xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        drain();
        chk("t4_pass", pass_cnt, 2);
        chk("t4_done", done, 1);
        chk("t4_fail", fail_cnt, 0);

        // restart at pass_cnt=2 with a bad transaction in flight
        pulse_start(16'd4);
        xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        xfer(3'b000, 4'h1, 4'h2, 4'hF, 1'b0);
        chk("t5_pass_before", pass_cnt, 2);
        pulse_start(16'd4);
        chk("t5_pass_clr", pass_cnt, 0);
        chk("t5_fail_clr", fail_cnt, 0);
        chk("t5_busy", busy, 1);
        for (int i = 0; i < 4; i++) xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        drain();
        chk("t5_pass", pass_cnt, 4);
        chk("t5_fail", fail_cnt, 0);
        chk("t5_ff_valid", ff_valid, 0);
        chk("t5_done", done, 1);

        // zero-length run
        pulse_start(16'd0);
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 0);
        chk("t6_pass", pass_cnt, 0);
        chk("t6_all_pass", all_pass, !COV);

`ifdef ALU_CHK_COVER_EN
        pulse_start(16'd8);
        for (int i = 0; i < 8; i++) xfer(3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        drain();
        chk("t7_op_seen", op_seen, 8'h01);
        chk("t7_pass", pass_cnt, 8);
        chk("t7_all_pass", all_pass, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
